cp0_unit: RTL and testbench

//  Coprocessor 0 responder. Services the CP0 read/write requests that the ID

---
 rtl/cp0_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_cp0_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: Coprocessor 0 responder.
// Serves MFC0/MTC0 requests and owns the Count/Compare timer, the Cause
// interrupt-pending bits and the exception-side register updates. A write
// whose operand is still a reservation-station tag parks in a one-entry slot
// until the matching CDB broadcast arrives.
`timescale 1ns/1ps
module cp0_unit #(
  parameter int          RSID_WIDTH = 4,
  parameter logic [31:0] PRID_VALUE = 32'h00004220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_addr,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic                  req_write_is_rsid,
  input  logic [31:0]           req_write_data,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [31:0]           cdb_data,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  input  logic [5:0]            hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_epc,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  exc_has_badvaddr,
  output logic                  int_req,
  output logic                  timer_int
);

  // {rd, sel} addresses of the implemented registers
  localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] A_PRID     = {5'd15, 3'd0};

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state;
  logic [7:0]            pend_addr;
  logic [RSID_WIDTH-1:0] pend_tag;

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic        count_tog;
  logic [31:0] compare;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [5:0]  cause_ip_hw;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic [RSID_WIDTH-1:0] req_tag;
  logic                  accept;
  logic                  wr_en;
  logic [7:0]            wr_addr;
  logic [31:0]           wr_data;
  logic                  go_wait;
  logic                  wait_hit;
  logic                  exc_shadow;
  logic                  wr_count;
  logic                  wr_compare;
  logic                  wr_status;
  logic                  wr_cause;
  logic                  wr_epc;
  logic                  count_inc;
  logic [31:0]           count_plus;
  logic [7:0]            cause_ip;
  logic [31:0]           status_word;
  logic [31:0]           cause_word;
  logic [31:0]           rd_mux;

  assign req_tag   = req_write_data[RSID_WIDTH-1:0];
  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign wait_hit  = cdb_valid && (cdb_rsid == pend_tag);

  // Select the single register write of this cycle: direct value, same-cycle
  // CDB bypass of a tag, or resolution of the parked tag write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req_addr;
    wr_data = req_write_data;
    go_wait = 1'b0;
    if (state == S_WAIT) begin
      wr_addr = pend_addr;
      wr_data = cdb_data;
      wr_en   = wait_hit && !exc_valid;
    end else if (accept && req_write) begin
      if (!req_write_is_rsid) begin
        wr_en = 1'b1;
      end else if (cdb_valid && (cdb_rsid == req_tag)) begin
        wr_en   = 1'b1;
        wr_data = cdb_data;
      end else if (!exc_valid) begin
        go_wait = 1'b1;
      end
    end
  end

  // An exception owns Status/Cause/EPC in the cycle it commits
  assign exc_shadow = exc_valid &&
                      ((wr_addr == A_STATUS) || (wr_addr == A_CAUSE) || (wr_addr == A_EPC));
  assign wr_count   = wr_en && (wr_addr == A_COUNT);
  assign wr_compare = wr_en && (wr_addr == A_COMPARE);
  assign wr_status  = wr_en && (wr_addr == A_STATUS) && !exc_shadow;
  assign wr_cause   = wr_en && (wr_addr == A_CAUSE)  && !exc_shadow;
  assign wr_epc     = wr_en && (wr_addr == A_EPC)    && !exc_shadow;

  assign count_inc  = count_tog && !wr_count;
  assign count_plus = count + 32'd1;

  assign cause_ip    = {cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw};
  assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_word  = {1'b0, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'd0};

  // Read multiplexer over the architectural view of each register
  always_comb begin
    rd_mux = 32'd0;
    case (req_addr)
      A_BADVADDR: rd_mux = badvaddr;
      A_COUNT:    rd_mux = count;
      A_COMPARE:  rd_mux = compare;
      A_STATUS:   rd_mux = status_word;
      A_CAUSE:    rd_mux = cause_word;
      A_EPC:      rd_mux = epc;
      A_PRID:     rd_mux = PRID_VALUE;
      default:    rd_mux = 32'd0;
    endcase
  end

  // Request FSM: park unresolved tag writes, drop them on exception
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend_addr <= 8'd0;
      pend_tag  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_wait) begin
            state     <= S_WAIT;
            pend_addr <= req_addr;
            pend_tag  <= req_tag;
          end
        end
        S_WAIT: begin
          if (exc_valid || wait_hit) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Count advances every second cycle; Compare match raises TI, Compare write clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 32'd0;
      count_tog <= 1'b0;
      compare   <= 32'd0;
      cause_ti  <= 1'b0;
    end else begin
      if (wr_count) begin
        count     <= wr_data;
        count_tog <= 1'b0;
      end else begin
        count_tog <= !count_tog;
        if (count_inc) count <= count_plus;
      end
      if (wr_compare) compare <= wr_data;
      if (wr_compare) cause_ti <= 1'b0;
      else if (count_inc && (count_plus == compare)) cause_ti <= 1'b1;
    end
  end

  // Status/Cause/EPC/BadVAddr: software writes and exception commit
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr    <= 32'd0;
      status_im   <= 8'd0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_ip_sw <= 2'd0;
      cause_ip_hw <= 6'd0;
      cause_exc   <= 5'd0;
      epc         <= 32'd0;
    end else begin
      cause_ip_hw <= hw_int;
      if (wr_status) begin
        status_im  <= wr_data[15:8];
        status_exl <= wr_data[1];
        status_ie  <= wr_data[0];
      end
      if (wr_cause) cause_ip_sw <= wr_data[9:8];
      if (wr_epc)   epc         <= wr_data;
      if (exc_valid) begin
        status_exl <= 1'b1;
        epc        <= exc_epc;
        cause_exc  <= exc_code;
        if (exc_has_badvaddr) badvaddr <= exc_badvaddr;
      end
    end
  end

  // Read response, one cycle after acceptance; a read+write is a write only
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
    end else begin
      rd_valid <= accept && req_read && !req_write;
      if (accept && req_read && !req_write) rd_data <= rd_mux;
    end
  end

  // Registered interrupt request
  always_ff @(posedge clk) begin
    if (rst) int_req <= 1'b0;
    else     int_req <= status_ie && !status_exl && |(cause_ip & status_im);
  end

  assign timer_int = cause_ti;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scenarios plus randomized traffic for cp0_unit,
// checked every cycle against a behavioural CP0 model.
`timescale 1ns/1ps
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h00004220;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_read, req_write, req_write_is_rsid;
  logic [7:0]  req_addr;
  logic [31:0] req_write_data;
  logic        cdb_valid;
  logic [3:0]  cdb_rsid;
  logic [31:0] cdb_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [5:0]  hw_int;
  logic        exc_valid, exc_has_badvaddr;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr;
  logic        int_req, timer_int;

  cp0_unit #(.RSID_WIDTH(4), .PRID_VALUE(PRID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_read(req_read), .req_write(req_write),
    .req_write_is_rsid(req_write_is_rsid), .req_write_data(req_write_data),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_has_badvaddr(exc_has_badvaddr),
    .int_req(int_req), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: architectural register contents
  logic [31:0] m_badv, m_count, m_compare, m_epc;
  int          m_ticks;          // cycles since Count was last loaded
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_ti;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_hw;
  logic [4:0]  m_exc;
  logic        m_wait;
  logic [7:0]  m_waddr;
  logic [3:0]  m_wtag;
  logic        exp_rdv, exp_int;
  logic [31:0] exp_rd;

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40: return m_badv;
      8'h48: return m_count;
      8'h58: return m_compare;
      8'h60: return 32'h00400000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      8'h68: return (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
      8'h70: return m_epc;
      8'h78: return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    logic        wr, incr, prot;
    logic [7:0]  wa;
    logic [31:0] wd;
    if (rst) begin
      m_badv = 0; m_count = 0; m_compare = 0; m_epc = 0; m_ticks = 0;
      m_im = 0; m_exl = 0; m_ie = 0; m_ti = 0; m_ipsw = 0; m_hw = 0; m_exc = 0;
      m_wait = 0; m_waddr = 0; m_wtag = 0; exp_rdv = 0; exp_int = 0;
      return;
    end
    exp_int = m_ie && !m_exl && ((m_ip() & m_im) != 0);
    exp_rdv = req_valid && !m_wait && req_read && !req_write;
    if (exp_rdv) exp_rd = m_read(req_addr);
    wr = 0; wa = req_addr; wd = req_write_data;
    if (m_wait) begin
      if (exc_valid) m_wait = 0;
      else if (cdb_valid && cdb_rsid == m_wtag) begin
        wr = 1; wa = m_waddr; wd = cdb_data; m_wait = 0;
      end
    end else if (req_valid && req_write) begin
      if (!req_write_is_rsid) wr = 1;
      else if (cdb_valid && cdb_rsid == req_write_data[3:0]) begin wr = 1; wd = cdb_data; end
      else if (!exc_valid) begin m_wait = 1; m_waddr = req_addr; m_wtag = req_write_data[3:0]; end
    end
    incr = 0;
    if (wr && wa == 8'h48) begin
      m_count = wd; m_ticks = 0;
    end else begin
      m_ticks++;
      if (m_ticks % 2 == 0) begin m_count = m_count + 1; incr = 1; end
    end
    if (wr && wa == 8'h58) begin m_compare = wd; m_ti = 0; end
    else if (incr && m_count == m_compare) m_ti = 1;
    prot = exc_valid && (wa == 8'h60 || wa == 8'h68 || wa == 8'h70);
    if (wr && !prot) begin
      if (wa == 8'h60) begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
      if (wa == 8'h68) m_ipsw = wd[9:8];
      if (wa == 8'h70) m_epc = wd;
    end
    if (exc_valid) begin
      m_exl = 1; m_epc = exc_epc; m_exc = exc_code;
      if (exc_has_badvaddr) m_badv = exc_badvaddr;
    end
    m_hw = hw_int;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  task automatic compare_outputs();
    check("req_ready", 32'(req_ready), 32'(!rst && !m_wait));
    check("rd_valid", 32'(rd_valid), 32'(exp_rdv));
    if (exp_rdv) check("rd_data", rd_data, exp_rd);
    check("int_req", 32'(int_req), 32'(exp_int));
    check("timer_int", 32'(timer_int), 32'(m_ti));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic set_idle();
    req_valid = 0; req_read = 0; req_write = 0; req_write_is_rsid = 0;
    req_addr = 0; req_write_data = 0;
    cdb_valid = 0; cdb_rsid = 0; cdb_data = 0;
    exc_valid = 0; exc_code = 0; exc_epc = 0; exc_badvaddr = 0; exc_has_badvaddr = 0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    set_idle(); req_valid = 1; req_write = 1; req_addr = a; req_write_data = d;
    tick(); set_idle();
  endtask

  task automatic do_read(input logic [7:0] a);
    set_idle(); req_valid = 1; req_read = 1; req_addr = a;
    tick(); set_idle();
  endtask

  task automatic random_cycle();
    logic [7:0] addrs [8];
    int r;
    addrs = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h00};
    set_idle();
    rst = ($urandom_range(0, 199) == 0);
    req_valid = ($urandom_range(0, 99) < 70);
    r = $urandom_range(0, 9);
    req_read  = (r < 5) || (r == 9);
    req_write = (r >= 5);
    req_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 7)];
    req_write_is_rsid = ($urandom_range(0, 99) < 30);
    req_write_data = $urandom;
    if (req_addr == 8'h58 && $urandom_range(0, 1) == 1)
      req_write_data = m_count + 32'($urandom_range(0, 8));
    if (req_addr == 8'h48 && $urandom_range(0, 1) == 1)
      req_write_data = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
    if (req_write_is_rsid) req_write_data = 32'($urandom_range(0, 15));
    cdb_valid = ($urandom_range(0, 99) < 40);
    cdb_rsid  = (m_wait && $urandom_range(0, 1) == 1) ? m_wtag : 4'($urandom_range(0, 15));
    cdb_data  = $urandom;
    exc_valid = ($urandom_range(0, 99) < 4);
    exc_code  = 5'($urandom);
    exc_epc   = $urandom;
    exc_badvaddr = $urandom;
    exc_has_badvaddr = $urandom_range(0, 1) == 1;
    if ($urandom_range(0, 19) == 0) hw_int = 6'($urandom);
    tick();
  endtask

  initial begin
    set_idle();
    hw_int = 0;
    rst = 1;
    tick(); tick();
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_int_req", 32'(int_req), 32'd0);
    check("reset_timer_int", 32'(timer_int), 32'd0);
    rst = 0;
    tick();
    check("ready_after_reset", 32'(req_ready), 32'd1);

    do_read(8'h60);
    check("status_rd_valid", 32'(rd_valid), 32'd1);
    check("status_reset_val", rd_data, 32'h00400000);
    do_read(8'h78);
    check("prid", rd_data, PRID);

    // Tag write to Compare, resolved by a later CDB broadcast
    set_idle(); req_valid = 1; req_write = 1; req_write_is_rsid = 1;
    req_addr = 8'h58; req_write_data = 32'd3;
    tick(); set_idle();
    check("tag_wait_ready", 32'(req_ready), 32'd0);
    cdb_valid = 1; cdb_rsid = 4'd2; cdb_data = 32'd99;
    tick(); set_idle();
    check("tag_wrong_rsid_ready", 32'(req_ready), 32'd0);
    cdb_valid = 1; cdb_rsid = 4'd3; cdb_data = 32'd10;
    tick(); set_idle();
    check("tag_resolved_ready", 32'(req_ready), 32'd1);
    do_read(8'h58);
    check("compare_from_cdb", rd_data, 32'd10);

    // Tag write to EPC bypassed by a same-cycle CDB match
    set_idle(); req_valid = 1; req_write = 1; req_write_is_rsid = 1;
    req_addr = 8'h70; req_write_data = 32'd7;
    cdb_valid = 1; cdb_rsid = 4'd7; cdb_data = 32'h12345678;
    tick(); set_idle();
    check("bypass_ready", 32'(req_ready), 32'd1);
    do_read(8'h70);
    check("epc_bypass", rd_data, 32'h12345678);

    // Timer interrupt
    do_write(8'h48, 32'd0);
    do_write(8'h58, 32'd6);
    for (int i = 0; i < 40 && !timer_int; i++) tick();
    check("timer_int_set", 32'(timer_int), 32'd1);
    do_write(8'h60, 32'h00008001);
    tick();
    check("int_req_set", 32'(int_req), 32'd1);
    do_write(8'h58, 32'd100);
    check("ti_cleared", 32'(timer_int), 32'd0);

    // Exception aborts a parked write
    set_idle(); req_valid = 1; req_write = 1; req_write_is_rsid = 1;
    req_addr = 8'h60; req_write_data = 32'd5;
    tick(); set_idle();
    check("wait_tag5", 32'(req_ready), 32'd0);
    exc_valid = 1; exc_code = 5'd4; exc_epc = 32'h80001000;
    tick(); set_idle();
    check("exc_ready", 32'(req_ready), 32'd1);
    cdb_valid = 1; cdb_rsid = 4'd5; cdb_data = 32'hFFFFFFFF;
    tick(); set_idle();
    do_read(8'h60);
    check("status_after_exc", rd_data, 32'h00408003);
    do_read(8'h68);
    check("cause_after_exc", rd_data, 32'h00000010);
    do_read(8'h70);
    check("epc_after_exc", rd_data, 32'h80001000);

    // Count wrap and hardware interrupt sampling
    do_write(8'h48, 32'hFFFFFFFF);
    tick(); tick();
    do_read(8'h48);
    check("count_wrap", rd_data, 32'd0);
    hw_int = 6'b000001;
    tick();
    do_read(8'h68);
    check("cause_ip2", rd_data, 32'h00000410);

    for (int i = 0; i < 3000; i++) random_cycle();
    rst = 0;
    set_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
